// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a DEPTH x DATA_WIDTH register memory.
// Supports per-transfer programmable wait states, out-of-range error responses and a sticky protocol-error flag.
module apb_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [WAIT_WIDTH-1:0] wait_cfg,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  prot_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never flags an error.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  prot_err_q, prot_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  setup_phase;
  logic                  access_phase;
  logic                  addr_err;
  logic                  prot_viol;
  logic                  mem_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup_phase  = psel & ~penable;
  assign access_phase = psel & penable;
  assign addr_err     = ({1'b0, paddr} >= DEPTH_L);
  assign rd_idx       = paddr[IDX_W-1:0];
  assign wr_idx       = addr_q[IDX_W-1:0];
  assign rd_word      = mem_q[rd_idx];

  // State register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and protocol-violation detection
  always_comb begin
    state_d   = state_q;
    prot_viol = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          state_d = (wait_cfg == '0) ? ST_ACCESS : ST_WAIT;
        end else if (access_phase) begin
          prot_viol = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          prot_viol = 1'b1;
        end else if ((paddr != addr_q) || (pwrite != write_q)) begin
          prot_viol = 1'b1;
        end else if (penable && (cnt_q == WAIT_WIDTH'(1))) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          prot_viol = 1'b1;
        end else if (penable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (prot_viol) begin
      state_d = ST_IDLE;
    end
  end

  // Output and datapath logic
  always_comb begin
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    prot_err_d = prot_err_q | prot_viol;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b0;
        if (setup_phase) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = addr_err;
          cnt_d   = wait_cfg;
          if (wait_cfg == '0) begin
            pslverr_d = addr_err;
          end else begin
            pready_d = 1'b0;
          end
          // Read data is fetched at setup so it is stable for the whole access phase.
          if (!pwrite) begin
            prdata_d = addr_err ? '0 : rd_word;
          end
        end
      end
      ST_WAIT: begin
        if (access_phase) begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
          if (cnt_q == WAIT_WIDTH'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
      ST_ACCESS: begin
        if (access_phase) begin
          mem_we    = write_q & ~err_q;
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
        end
      end
      default: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b0;
      end
    endcase
    if (prot_viol) begin
      pready_d  = 1'b1;
      pslverr_d = 1'b0;
      cnt_d     = '0;
      mem_we    = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (mem_we && (wr_idx == IDX_W'(i))) ? wdata_q : mem_q[i];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      pready_q   <= 1'b1;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Memory is cleared by reset, so it is a flop array rather than a RAM macro.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign prot_err = prot_err_q;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer (slave) holding a DEPTH x DATA_WIDTH register memory. It responds to the APB master's psel/penable/pwrite/paddr/pwdata and returns prdata/pready/pslverr. Wait states are programmable per transfer, and out-of-range accesses complete with an error. It is the responder end of the APB master already in the codebase, and is instantiated under the same APB top.

Parameters:
ADDR_WIDTH, 8, width of paddr
DATA_WIDTH, 16, width of pwdata/prdata
DEPTH, 128, number of implemented words; must be <= 2**ADDR_WIDTH; addresses >= DEPTH are out of range
WAIT_WIDTH, 4, width of wait_cfg

Ports:
pclk  in  1  clock, all state on rising edge
preset  in  1  reset, asynchronous, active-high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  word address
pwdata  in  DATA_WIDTH  write data
wait_cfg  in  WAIT_WIDTH  wait states to insert; sampled in setup phase
prdata  out  DATA_WIDTH  read data, valid when psel&penable&pready&!pwrite
pready  out  1  transfer-complete handshake
pslverr  out  1  error response, qualified by pready in access phase
prot_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (preset=1, async): pready=1, pslverr=0, prdata=0, prot_err=0, wait counter=0, FSM=IDLE, all memory words=0. Reset mid-transfer aborts the transfer with no memory write.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE: pready=1, pslverr=0.
  - Setup detected (psel=1, penable=0): latch paddr, pwrite, pwdata; compute err = (paddr >= DEPTH).
  - If wait_cfg==0 -> ACCESS; pready stays 1; pslverr<=err.
  - Else -> WAIT; pready<=0; cnt<=wait_cfg.
  - Read setup, no error: prdata<=mem[paddr] at the same edge. Read setup with err: prdata<=0.
- WAIT: pready=0, pslverr=0. Each cycle with psel&penable, cnt decrements. When cnt==1: pready<=1, pslverr<=err, -> ACCESS. Exactly wait_cfg cycles show pready=0.
- ACCESS (completion cycle, psel&penable&pready):
  - Write with !err: mem[addr]<=pwdata at the closing edge. Writes with err are dropped.
  - Next state: pslverr<=0, pready<=1.
  - If the completing cycle is followed by a new setup, that setup is detected from IDLE on the next cycle, so back-to-back transfers have no idle penalty beyond the APB setup phase.
- prdata holds its last value outside read completion. prdata is not cleared after the transfer.
- Latency: a zero-wait transfer takes 2 cycles (setup + access). An N-wait transfer takes N+2 cycles.
- wait_cfg changes after setup are ignored for that transfer.
- Protocol violations set prot_err=1 (sticky until reset), and the FSM returns to IDLE with no write:
  - psel deasserts in WAIT or ACCESS before completion.
  - penable=1 without a preceding setup in IDLE.
  - paddr or pwrite changing during WAIT.
- Address wrap: no wrap. Only paddr < DEPTH maps to storage. DEPTH == 2**ADDR_WIDTH means pslverr never fires.
- psel=0: outputs hold idle values (pready=1, pslverr=0).

Test Plan:
- Assert preset async mid-cycle during a WAIT-state write to addr 5 -> outputs immediately pready=1, pslverr=0, prdata=0, prot_err=0; subsequent read of addr 5 returns 0.
- wait_cfg=0: write 0xA5A5 to addr 3, then read addr 3 -> each transfer takes 2 cycles, pready=1 in the access cycle, read prdata=0xA5A5, pslverr=0.
- wait_cfg=3: write 0x1234 to addr 0x10 -> pready=0 for exactly 3 access cycles, then 1; memory is updated only at completion; read with wait_cfg=3 returns 0x1234 after 3 waits.
- Out-of-range (DEPTH=128): write 0xFFFF to addr 0x80, then read addr 0x80 -> both complete with pslverr=1 and pready=1, read prdata=0; addr 0x00 is unchanged.
- Back-to-back: write addr 1=0x0001, write addr 2=0x0002, read addr 1, read addr 2 with no idle cycles, wait_cfg alternating 0/2 -> correct data and correct pready low-cycle counts per transfer.
- Drop psel during the WAIT of a write to addr 7 (wait_cfg=4) -> prot_err=1 and stays 1, addr 7 is not written, the next legal transfer completes normally.
